// File: rtl/override_sequencer.sv
// override_sequencer: round-robin arbitration of force/release overrides
// applied to one datapath value between its normal driver and consumer.
// Handshake: req_ready is a combinational one-hot accept strobe. A requester
// is granted in the cycle where req_valid[i] and req_ready[i] are both high.
// req_valid may drop at any time before that cycle with no side effect.
module override_sequencer #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         driven_value,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_value,
    input  logic [NUM_REQ*CNT_W-1:0] req_cycles,
    input  logic [NUM_REQ-1:0]       req_sticky,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     abort,
    output logic [WIDTH-1:0]         out_value,
    output logic                     forcing,
    output logic                     holding,
    output logic [NUM_REQ-1:0]       owner,
    output logic                     done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FORCE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [WIDTH-1:0]   r_val;
    logic [WIDTH-1:0]   r_snap;
    logic [WIDTH-1:0]   r_out;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sticky;
    logic               r_done;
    logic [NUM_REQ-1:0] r_owner;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    int                 w_idx;
    logic               w_grant;
    logic               w_expire;
    logic [WIDTH-1:0]   w_win_val;
    logic [CNT_W-1:0]   w_win_cyc;
    logic [CNT_W-1:0]   w_load;
    logic               w_win_sticky;
    logic [PTR_W-1:0]   w_ptr_next;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(w_idx);
            end
        end
    end

    // Grant qualification, winner payload and expiry decode.
    always_comb begin
        w_grant      = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !abort && w_found;
        req_ready    = w_grant ? (NUM_REQ'(1) << w_win) : '0;
        w_win_val    = req_value[int'(w_win)*WIDTH +: WIDTH];
        w_win_cyc    = req_cycles[int'(w_win)*CNT_W +: CNT_W];
        w_win_sticky = req_sticky[w_win];
        // A zero duration still forces for one cycle.
        w_load       = (w_win_cyc == '0) ? CNT_W'(1) : w_win_cyc;
        w_ptr_next   = (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + PTR_W'(1);
        // abort outranks the window running out, so no done pulse on abort.
        w_expire     = (r_state == S_FORCE) && !abort && (r_cnt == CNT_W'(1));
    end

    // Next-state decode; abort always wins, a grant out of HOLD preempts it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_next_state = S_FORCE;
            end
            S_FORCE: begin
                if (abort)         w_next_state = S_IDLE;
                else if (w_expire) w_next_state = r_sticky ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (abort)                            w_next_state = S_IDLE;
                else if (w_grant)                     w_next_state = S_FORCE;
                else if (driven_value != r_snap)      w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Capture, counter, pointer, snapshot, owner and output value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_val    <= '0;
            r_snap   <= '0;
            r_out    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_done   <= 1'b0;
            r_owner  <= '0;
        end else begin
            r_done <= w_expire;
            if (w_grant) begin
                r_val    <= w_win_val;
                r_cnt    <= w_load;
                r_sticky <= w_win_sticky;
                r_ptr    <= w_ptr_next;
                r_owner  <= req_ready;
            end else if (r_state == S_FORCE) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_expire && r_sticky) r_snap <= driven_value;
            if (w_next_state == S_IDLE) r_owner <= '0;
            case (w_next_state)
                S_FORCE: r_out <= w_grant ? w_win_val : r_val;
                S_HOLD:  r_out <= r_out;
                default: r_out <= driven_value;
            endcase
        end
    end

    assign out_value = r_out;
    assign forcing   = (r_state == S_FORCE);
    assign holding   = (r_state == S_HOLD);
    assign owner     = r_owner;
    assign done      = r_done;

endmodule
